// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: operation encoding, flag
// positions and the combinational compute function used by the datapath.
package alu_pipe_pkg;

    // Operation encoding; codes 10..15 are illegal and flow through with err set
    typedef enum logic [3:0] {
        ADD     = 4'd0,
        SUB     = 4'd1,
        MULT    = 4'd2,
        BITAND  = 4'd3,
        BITOR   = 4'd4,
        BITXOR  = 4'd5,
        FUNCLSL = 4'd6,
        FUNCLSR = 4'd7,
        FUNCRL  = 4'd8,
        FUNCRR  = 4'd9
    } op_t;

    // Bit positions inside the {err, v, c, z} flag vector
    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_ERR = 3;
    localparam int NFLAGS   = 4;

    // The compute function works on a fixed 64-bit container; WIDTH must not exceed it
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0]  r;
        logic [NFLAGS-1:0] flags;
    } alu_res_t;

    // Single bit of a vector at a run-time position, kept as a shift so the
    // index width never has to match the vector width
    function automatic logic bit_at(input logic [MAX_W:0] x, input int unsigned i);
        logic [MAX_W:0] t;
        t = x >> i;
        return t[0];
    endfunction

    // Result and flags for one operation on w-bit operands held in the low bits
    // of a and b; sh is the already extracted shift amount
    function automatic alu_res_t alu_compute(input op_t op,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned sh,
                                             input int unsigned w);
        alu_res_t res;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] hmask;
        logic [MAX_W-1:0] am;
        logic [MAX_W-1:0] bm;
        logic [MAX_W:0]   wide;
        logic             sa;
        logic             sb;
        logic             sr;
        int unsigned      rot;

        res   = '0;
        mask  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        hmask = (MAX_W'(1) << (w / 2)) - MAX_W'(1);
        am    = a & mask;
        bm    = b & mask;
        sa    = bit_at({1'b0, am}, w - 1);
        sb    = bit_at({1'b0, bm}, w - 1);
        rot   = sh % w;
        wide  = '0;

        case (op)
            ADD: begin
                wide              = {1'b0, am} + {1'b0, bm};
                res.r             = wide[MAX_W-1:0] & mask;
                res.flags[FLAG_C] = bit_at(wide, w);
            end
            SUB: begin
                wide              = {1'b0, am} - {1'b0, bm};
                res.r             = wide[MAX_W-1:0] & mask;
                res.flags[FLAG_C] = (am >= bm);
            end
            MULT:    res.r = ((am & hmask) * (bm & hmask)) & mask;
            BITAND:  res.r = am & bm;
            BITOR:   res.r = am | bm;
            BITXOR:  res.r = am ^ bm;
            FUNCLSL: res.r = (am << sh) & mask;
            FUNCLSR: res.r = am >> sh;
            FUNCRL:  res.r = (rot == 0) ? am : (((am << rot) | (am >> (w - rot))) & mask);
            FUNCRR:  res.r = (rot == 0) ? am : (((am >> rot) | (am << (w - rot))) & mask);
            default: res.flags[FLAG_ERR] = 1'b1;
        endcase

        sr = bit_at({1'b0, res.r}, w - 1);
        if (op == ADD) begin
            res.flags[FLAG_V] = (sa == sb) && (sr != sa);
        end else if (op == SUB) begin
            res.flags[FLAG_V] = (sa != sb) && (sr != sa);
        end
        res.flags[FLAG_Z] = !res.flags[FLAG_ERR] && (res.r == '0);
        return res;
    endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// One valid/ready register slice. It accepts new data whenever it is empty or
// its own content is leaving this cycle, so empty slots (bubbles) collapse.
module alu_pipe_slice
    import alu_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load on every opportunity; the payload only changes when a real op arrives,
    // so a held (stalled) output never moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute on the input operands, registered into
// the first of STAGES valid/ready slices, with a tag travelling alongside.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  op_t               in_op,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_r,
    output logic [3:0]        out_flags,
    output logic [ID_W-1:0]   out_id
);

    localparam int SHW = $clog2(WIDTH);
    localparam int PW  = ID_W + NFLAGS + WIDTH;

    alu_res_t      res;
    logic [STAGES:0] chain_valid;
    logic [STAGES:0] chain_ready;
    logic [PW-1:0]   chain_data [0:STAGES];

    // Evaluate the requested operation directly on the presented operands
    always_comb begin
        res = alu_compute(in_op, MAX_W'(in_a), MAX_W'(in_b), 32'(in_b[SHW-1:0]), WIDTH);
    end

    // Only the low WIDTH bits of the 64-bit compute container carry the result
    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res.r[MAX_W-1:WIDTH];
    end

    assign chain_valid[0] = in_valid;
    assign chain_data[0]  = {in_id, res.flags, res.r[WIDTH-1:0]};

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        alu_pipe_slice #(
            .PW(PW)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (chain_valid[i]),
            .in_ready  (chain_ready[i]),
            .in_data   (chain_data[i]),
            .out_valid (chain_valid[i+1]),
            .out_ready (chain_ready[i+1]),
            .out_data  (chain_data[i+1])
        );
    end

    assign chain_ready[STAGES] = out_ready;

    // Nothing may be accepted while reset is held, even though the slices are empty
    assign in_ready  = !rst && chain_ready[0];
    assign out_valid = chain_valid[STAGES];
    assign out_r     = chain_data[STAGES][WIDTH-1:0];
    assign out_flags = chain_data[STAGES][WIDTH+NFLAGS-1:WIDTH];
    assign out_id    = chain_data[STAGES][PW-1:WIDTH+NFLAGS];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a main 32-bit/2-stage instance plus 16-bit instances with
// one and four stages, all checked against a plain-arithmetic reference model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W    = 32;
    localparam int S    = 2;
    localparam int ID_W = 4;
    localparam int AW   = 16;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     r;
        logic [3:0]      f;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]    in_a, in_b, out_r;
    op_t             in_op;
    logic [ID_W-1:0] in_id, out_id;
    logic [3:0]      out_flags;

    logic            ax_valid, ax_out_ready;
    logic            ax_ready1, ax_ready4, ax_ov1, ax_ov4;
    logic [AW-1:0]   ax_r1, ax_r4;
    logic [3:0]      ax_f1, ax_f4;
    logic [ID_W-1:0] ax_id1, ax_id4;

    int   checks = 0;
    int   errors = 0;
    int   n_deliv = 0;
    bit   saw_accept, saw_deliver;
    exp_t q[$], q1[$], q4[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .STAGES(S), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_flags(out_flags), .out_id(out_id)
    );

    alu_pipe #(.WIDTH(AW), .STAGES(1), .ID_W(ID_W)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(ax_valid), .in_ready(ax_ready1),
        .in_a(in_a[AW-1:0]), .in_b(in_b[AW-1:0]), .in_op(in_op), .in_id(in_id),
        .out_valid(ax_ov1), .out_ready(ax_out_ready), .out_r(ax_r1),
        .out_flags(ax_f1), .out_id(ax_id1)
    );

    alu_pipe #(.WIDTH(AW), .STAGES(4), .ID_W(ID_W)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(ax_valid), .in_ready(ax_ready4),
        .in_a(in_a[AW-1:0]), .in_b(in_b[AW-1:0]), .in_op(in_op), .in_id(in_id),
        .out_valid(ax_ov4), .out_ready(ax_out_ready), .out_r(ax_r4),
        .out_flags(ax_f4), .out_id(ax_id4)
    );

    // Reference result from integer arithmetic on w-bit unsigned/signed values
    function automatic exp_t refModel(input op_t op, input longint a_in, input longint b_in,
                                      input int w, input logic [ID_W-1:0] id);
        exp_t   e;
        longint m, h, a, b, r, sa, sb, sr;
        int     sh;
        bit     c, v, err;
        m  = 1;
        m  = m << w;
        h  = 1;
        h  = h << (w / 2);
        a  = a_in % m;
        b  = b_in % m;
        sh = int'(b % (longint'(1) << $clog2(w)));
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        c = 1'b0; v = 1'b0; err = 1'b0; r = 0;
        case (op)
            ADD: begin
                r = a + b; c = (r >= m); sr = sa + sb;
                v = (sr >= m / 2) || (sr < -(m / 2));
            end
            SUB: begin
                r = a - b; c = (a >= b); sr = sa - sb;
                v = (sr >= m / 2) || (sr < -(m / 2));
            end
            MULT:    r = (a % h) * (b % h);
            BITAND:  r = a & b;
            BITOR:   r = a | b;
            BITXOR:  r = a ^ b;
            FUNCLSL: r = (sh >= w) ? 0 : (a << sh);
            FUNCLSR: r = (sh >= w) ? 0 : (a >> sh);
            FUNCRL: begin
                r = a;
                repeat (sh) r = (r * 2) % m + ((r >= m / 2) ? 1 : 0);
            end
            FUNCRR: begin
                r = a;
                repeat (sh) r = r / 2 + (r % 2) * (m / 2);
            end
            default: err = 1'b1;
        endcase
        r    = ((r % m) + m) % m;
        e.id = id;
        e.r  = r[31:0];
        e.f  = {err, v, c, !err && (r == 0)};
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string who, input exp_t e, input logic [31:0] r,
                               input logic [3:0] f, input logic [ID_W-1:0] id);
        checkOutput({who, "_r"}, r, e.r);
        checkOutput({who, "_flags"}, f, e.f);
        checkOutput({who, "_id"}, id, e.id);
    endtask

    // One clock cycle: drive inputs, settle, score both channels, then advance
    task automatic applyStimulus(input bit v, input op_t op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [ID_W-1:0] id,
                                 input bit ordy, input bit has_exp = 1'b0,
                                 input logic [31:0] xr = '0, input logic [3:0] xf = '0);
        exp_t e;
        in_valid = v; in_op = op; in_a = a; in_b = b; in_id = id; out_ready = ordy;
        #1;
        saw_accept  = in_valid && in_ready;
        saw_deliver = out_valid && out_ready;
        if (saw_deliver) begin
            n_deliv++;
            if (q.size() == 0) checkOutput("main_deliv_without_op", out_valid, 1'b0);
            else checkResult("main", q.pop_front(), out_r, out_flags, out_id);
        end
        if (saw_accept) begin
            if (has_exp) begin
                e.id = id; e.r = xr; e.f = xf;
            end else begin
                e = refModel(op, longint'(a), longint'(b), W, id);
            end
            q.push_back(e);
        end
        if (ax_ov1) begin
            if (q1.size() == 0) checkOutput("s1_deliv_without_op", ax_ov1, 1'b0);
            else checkResult("s1", q1.pop_front(), {16'b0, ax_r1}, ax_f1, ax_id1);
        end
        if (ax_ov4) begin
            if (q4.size() == 0) checkOutput("s4_deliv_without_op", ax_ov4, 1'b0);
            else checkResult("s4", q4.pop_front(), {16'b0, ax_r4}, ax_f4, ax_id4);
        end
        if (ax_valid && ax_ready1)
            q1.push_back(refModel(op, longint'(a[AW-1:0]), longint'(b[AW-1:0]), AW, id));
        if (ax_valid && ax_ready4)
            q4.push_back(refModel(op, longint'(a[AW-1:0]), longint'(b[AW-1:0]), AW, id));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              lat, acc, nxt;
        logic [W-1:0]    va [8];
        logic [W-1:0]    vb [8];
        op_t             vop [8];
        logic [W-1:0]    h_r;
        logic [3:0]      h_f;
        logic [ID_W-1:0] h_id;

        rst = 1'b1; in_valid = 1'b0; in_op = ADD; in_a = '0; in_b = '0; in_id = '0;
        out_ready = 1'b0; ax_valid = 1'b0; ax_out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_r", out_r, '0);
        checkOutput("rst_out_flags", out_flags, '0);
        checkOutput("rst_out_id", out_id, '0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_rst", in_ready, 1'b1);

        // Latency of a single op into an empty pipe
        applyStimulus(1'b1, ADD, 32'hFFFF_FFFF, 32'h1, 4'd1, 1'b1, 1'b1, 32'h0, 4'b0011);
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            applyStimulus(1'b0, ADD, '0, '0, '0, 1'b1);
            if (saw_deliver) lat = i;
        end
        checkOutput("latency", lat, S);

        // Directed corner cases with hand-derived results
        applyStimulus(1'b1, ADD,     32'h7FFF_FFFF, 32'h1,         4'd2,  1'b1, 1'b1, 32'h8000_0000, 4'b0100);
        applyStimulus(1'b1, SUB,     32'd5,         32'd7,         4'd3,  1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0000);
        applyStimulus(1'b1, SUB,     32'd7,         32'd5,         4'd4,  1'b1, 1'b1, 32'h2,         4'b0010);
        applyStimulus(1'b1, SUB,     32'h8000_0000, 32'h1,         4'd5,  1'b1, 1'b1, 32'h7FFF_FFFF, 4'b0110);
        applyStimulus(1'b1, MULT,    32'h1234_FFFF, 32'h5678_FFFF, 4'd6,  1'b1, 1'b1, 32'hFFFE_0001, 4'b0000);
        applyStimulus(1'b1, FUNCRR,  32'h1,         32'h1,         4'd7,  1'b1, 1'b1, 32'h8000_0000, 4'b0000);
        applyStimulus(1'b1, FUNCLSL, 32'h1234_5678, 32'd32,        4'd8,  1'b1, 1'b1, 32'h1234_5678, 4'b0000);
        applyStimulus(1'b1, op_t'(4'd13), 32'hABCD, 32'h1234,      4'd9,  1'b1, 1'b1, 32'h0,         4'b1000);
        applyStimulus(1'b1, BITAND,  32'hF0,        32'h0F,        4'd10, 1'b1, 1'b1, 32'h0,         4'b0001);
        applyStimulus(1'b1, FUNCRL,  32'h8000_0001, 32'd4,         4'd11, 1'b1, 1'b1, 32'h18,        4'b0000);
        applyStimulus(1'b1, FUNCLSR, 32'h8000_0000, 32'd31,        4'd12, 1'b1, 1'b1, 32'h1,         4'b0000);
        applyStimulus(1'b1, BITXOR,  32'hAAAA_5555, 32'hFFFF_0000, 4'd13, 1'b1, 1'b1, 32'h5555_5555, 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, ADD, '0, '0, '0, 1'b1);
        checkOutput("directed_drained", q.size(), 0);

        // Backpressure: eight tagged ops against a stalled consumer
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vop[i] = op_t'(4'($urandom_range(0, 9)));
        end
        n_deliv = 0; nxt = 0; acc = 0; h_r = '0; h_f = '0; h_id = '0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vop[nxt], va[nxt], vb[nxt], 4'(nxt), 1'b0);
            if (saw_accept) begin
                nxt++;
                acc++;
            end
            if (i == 2) begin
                h_r = out_r; h_f = out_flags; h_id = out_id;
            end
        end
        checkOutput("stall_accepts", acc, S);
        checkOutput("stall_in_ready", in_ready, 1'b0);
        checkOutput("stall_out_valid", out_valid, 1'b1);
        checkOutput("stall_hold_r", out_r, h_r);
        checkOutput("stall_hold_flags", out_flags, h_f);
        checkOutput("stall_hold_id", out_id, h_id);
        for (int i = 0; i < 40 && n_deliv < 8; i++) begin
            if (nxt < 8) begin
                applyStimulus(1'b1, vop[nxt], va[nxt], vb[nxt], 4'(nxt), 1'b1);
                if (saw_accept) nxt++;
            end else begin
                applyStimulus(1'b0, ADD, '0, '0, '0, 1'b1);
            end
        end
        checkOutput("bp_delivered", n_deliv, 8);
        checkOutput("bp_queue_empty", q.size(), 0);

        // Random back-to-back stream on all three instances
        ax_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, op_t'(4'($urandom_range(0, 11))), $urandom, $urandom,
                          4'($urandom), 1'b1);
            if (i >= S) checkOutput("throughput", {saw_accept, saw_deliver}, 2'b11);
        end
        ax_valid = 1'b0;

        // Random valid and backpressure on the main instance
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, op_t'(4'($urandom_range(0, 11))),
                          $urandom, $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 20 && (q.size() != 0 || q1.size() != 0 || q4.size() != 0); i++)
            applyStimulus(1'b0, ADD, '0, '0, '0, 1'b1);
        checkOutput("random_main_drained", q.size(), 0);
        checkOutput("random_s1_drained", q1.size(), 0);
        checkOutput("random_s4_drained", q4.size(), 0);

        // Reset in the middle of a stream with ops in flight
        ax_valid = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADD, $urandom, $urandom, 4'(i), 1'b0);
        ax_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_out_r", out_r, '0);
        checkOutput("midrst_s1_valid", ax_ov1, 1'b0);
        checkOutput("midrst_s4_valid", ax_ov4, 1'b0);
        q.delete(); q1.delete(); q4.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_deliv = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, ADD, '0, '0, '0, 1'b1);
        checkOutput("midrst_none_delivered", n_deliv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
